sram_uart_dump: RTL and testbench
=================================

Name: sram_uart_dump

Overview:
- Reads a contiguous range of 16-bit words from external SRAM through the existing SRAM controller and serialises them out of UART TX as 8N1 bytes, high byte first.
- It is the transmit-side counterpart of the UART receive path that fills SRAM at power-up.
- It lets the board return decoded RGB or intermediate buffers to the host, for comparison against the software model.
- It sits beside the UART receiver under the top-level FSM and takes ownership of the SRAM port only while busy.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); minimum 2
SRAM_READ_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid; range 1..7

Ports:
Clock  input  1  50 MHz system clock
Resetn  input  1  asynchronous active-low reset
Start  input  1  single-cycle pulse; sampled only in S_IDLE
Base_address  input  18  first SRAM word address; captured on Start
Word_count  input  18  number of words to send; captured on Start
SRAM_address  output  18  read address to the SRAM controller
SRAM_we_n  output  1  write enable, active low; held 1 (read only)
SRAM_read_data  input  16  read data from the SRAM controller
Busy  output  1  high from the cycle after an accepted Start until Done
Done  output  1  one-cycle pulse when the last stop bit completes
UART_TX_O  output  1  serial line; idle high

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, Busy=0, Done=0, UART_TX_O=1, all counters 0, state S_IDLE.
- Reset mid-operation aborts at once: UART_TX_O=1 asynchronously, the partial byte is abandoned and Done is not pulsed.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_LATCH, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_NEXT.
- S_IDLE + Start:
  - Word_count==0: pulse Done next cycle, Busy stays 0, no SRAM access and no UART activity.
  - Otherwise: latch address and count, Busy<=1, go to S_REQ.
- Start in any other state is ignored.
- S_REQ: drive SRAM_address=current address; go to S_WAIT. SRAM_address holds until the next S_REQ.
- S_WAIT: count SRAM_READ_LATENCY-1 cycles, then go to S_LATCH.
- S_LATCH: capture SRAM_read_data into the 16-bit word register; byte_sel<=0 (high byte); go to S_START_BIT.
- S_START_BIT: UART_TX_O=0 for exactly CLKS_PER_BIT cycles.
- S_DATA_BITS:
  - Shift out the selected byte LSB first.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - A 3-bit bit counter goes 0..7.
- S_STOP_BIT: UART_TX_O=1 for exactly CLKS_PER_BIT cycles. Then:
  - byte_sel==0: byte_sel<=1, go to S_START_BIT (low byte).
  - byte_sel==1: go to S_NEXT.
- S_NEXT: decrement the remaining count and increment the address.
  - Remaining count reaches 0: Done=1 for one cycle, Busy<=0, go to S_IDLE.
  - Otherwise go to S_REQ.
- Address arithmetic is 18-bit and wraps 0x3FFFF -> 0x00000 without error.
- Timing per word: byte frame = 10*CLKS_PER_BIT cycles. Word time = 20*CLKS_PER_BIT + SRAM_READ_LATENCY + 3 cycles (S_REQ + S_LATCH + S_NEXT).
- UART_TX_O is driven from a register; no combinational glitches.
- Back-to-back bytes have no idle gap beyond the stop bit.
- The SRAM word is read exactly once per word. The module never writes SRAM.
- Start may be asserted again in the cycle after Done (state is S_IDLE) and is accepted.

Test Plan:
- Reset: hold Resetn=0 -> UART_TX_O=1, Busy=0, Done=0, SRAM_we_n=1, SRAM_address=0.
- Single word, CLKS_PER_BIT=4: SRAM[0x100]=16'hA55A, Start with Base=0x100, Count=1.
  - Line decodes bytes 0xA5 then 0x5A.
  - Each bit lasts 4 cycles.
  - Done pulses once, 80+SRAM_READ_LATENCY+3 cycles after Busy rises.
  - Exactly one SRAM_address=0x100 request.
- Multi-word and wrap: Base=0x3FFFE, Count=3, SRAM holding 0x0102, 0x0304, 0x0506 at 0x3FFFE, 0x3FFFF, 0x00000.
  - Line sequence is 01 02 03 04 05 06.
  - Addresses are issued in order 0x3FFFE, 0x3FFFF, 0x00000.
- Zero count: Start with Count=0 -> Done pulses on the next cycle, Busy never rises, UART_TX_O stays 1.
- Start while busy: second Start pulse mid-byte with different Base -> ignored; output is identical to the single-start run.
- Reset mid-byte: drop Resetn during a data bit of the high byte -> UART_TX_O=1 immediately and no Done.
  - After release, Start with Base=0x100, Count=1 yields a clean 0xA5, 0x5A.

Source files
------------

// File: rtl/sram_uart_dump.sv
// sram_uart_dump
// Reads Word_count 16-bit words from SRAM starting at Base_address and sends
// each one out of UART TX as two 8N1 bytes, high byte first.
//
// Ports:
//   Clock, Resetn      system clock, asynchronous active-low reset
//   Start              one-cycle request pulse, honoured only when idle
//   Base_address       first SRAM word address (captured on Start)
//   Word_count         number of words to send (captured on Start)
//   SRAM_address       registered read address to the SRAM controller
//   SRAM_we_n          tied high; this block only reads
//   SRAM_read_data     read data, valid SRAM_READ_LATENCY cycles after address
//   Busy               high while a dump is in progress
//   Done               one-cycle pulse after the last stop bit
//   UART_TX_O          registered serial output, idle high
module sram_uart_dump #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Busy,
  output logic        Done,
  output logic        UART_TX_O
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  // Address is live from the cycle after S_REQ, so S_WAIT spans the full
  // latency and S_LATCH lands on the first cycle the data is valid.
  localparam logic [2:0]    LAT_LAST = 3'(SRAM_READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LATCH, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_NEXT
  } state_t;

  state_t          r_state, w_state;
  logic [17:0]     r_addr, w_addr;
  logic [17:0]     r_cnt, w_cnt;
  logic [17:0]     r_sram_addr, w_sram_addr;
  logic [15:0]     r_word, w_word;
  logic            r_byte_sel, w_byte_sel;
  logic [2:0]      r_bit, w_bit;
  logic [2:0]      r_lat, w_lat;
  logic [CW-1:0]   r_clk, w_clk;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_tx, w_tx;
  logic [7:0]      w_byte;
  logic [2:0]      w_bit_inc;

  assign w_byte    = r_byte_sel ? r_word[7:0] : r_word[15:8];
  assign w_bit_inc = r_bit + 3'd1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_sram_addr <= '0;
      r_word      <= '0;
      r_byte_sel  <= 1'b0;
      r_bit       <= '0;
      r_lat       <= '0;
      r_clk       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_cnt       <= w_cnt;
      r_sram_addr <= w_sram_addr;
      r_word      <= w_word;
      r_byte_sel  <= w_byte_sel;
      r_bit       <= w_bit;
      r_lat       <= w_lat;
      r_clk       <= w_clk;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_tx        <= w_tx;
    end
  end

  // Next-state logic also computes the next line level, so the TX register
  // changes on the same edge as the state that owns that bit.
  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_cnt       = r_cnt;
    w_sram_addr = r_sram_addr;
    w_word      = r_word;
    w_byte_sel  = r_byte_sel;
    w_bit       = r_bit;
    w_lat       = r_lat;
    w_clk       = r_clk;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Word_count == 18'd0) begin
            w_done = 1'b1;
          end else begin
            w_addr  = Base_address;
            w_cnt   = Word_count;
            w_busy  = 1'b1;
            w_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_sram_addr = r_addr;
        w_lat       = '0;
        w_state     = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == LAT_LAST) w_state = S_LATCH;
        else                   w_lat   = r_lat + 3'd1;
      end
      S_LATCH: begin
        w_word     = SRAM_read_data;
        w_byte_sel = 1'b0;
        w_clk      = '0;
        w_tx       = 1'b0;
        w_state    = S_START_BIT;
      end
      S_START_BIT: begin
        w_tx = 1'b0;
        if (r_clk == CLK_LAST) begin
          w_clk   = '0;
          w_bit   = '0;
          w_tx    = w_byte[0];
          w_state = S_DATA_BITS;
        end else begin
          w_clk = r_clk + 1'b1;
        end
      end
      S_DATA_BITS: begin
        w_tx = w_byte[r_bit];
        if (r_clk == CLK_LAST) begin
          w_clk = '0;
          if (r_bit == 3'd7) begin
            w_tx    = 1'b1;
            w_state = S_STOP_BIT;
          end else begin
            w_bit = w_bit_inc;
            w_tx  = w_byte[w_bit_inc];
          end
        end else begin
          w_clk = r_clk + 1'b1;
        end
      end
      S_STOP_BIT: begin
        if (r_clk == CLK_LAST) begin
          w_clk = '0;
          if (!r_byte_sel) begin
            w_byte_sel = 1'b1;
            w_tx       = 1'b0;
            w_state    = S_START_BIT;
          end else begin
            w_state = S_NEXT;
          end
        end else begin
          w_clk = r_clk + 1'b1;
        end
      end
      S_NEXT: begin
        w_cnt  = r_cnt - 18'd1;
        w_addr = r_addr + 18'd1;
        if (r_cnt == 18'd1) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_state = S_REQ;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign SRAM_address = r_sram_addr;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign UART_TX_O    = r_tx;

endmodule

// File: tb/tb_sram_uart_dump.sv
module tb_sram_uart_dump;
  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int WORD_T = 20 * CPB + LAT + 3;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [17:0] Base_address, Word_count, SRAM_address;
  logic        SRAM_we_n, Busy, Done, UART_TX_O;
  logic [15:0] SRAM_read_data;

  sram_uart_dump #(.CLKS_PER_BIT(CPB), .SRAM_READ_LATENCY(LAT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start),
    .Base_address(Base_address), .Word_count(Word_count),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .Busy(Busy), .Done(Done),
    .UART_TX_O(UART_TX_O)
  );

  always #5 Clock = ~Clock;

  // SRAM model: data appears LAT cycles after the address is presented.
  logic [15:0] mem [0:262143];
  logic [17:0] ap [LAT];
  always @(posedge Clock) begin
    ap[0] <= SRAM_address;
    for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
  end
  assign SRAM_read_data = mem[ap[LAT-1]];

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Line monitor: decodes 8N1 frames by sampling mid-bit, records events.
  logic [7:0]  bytes_q[$];
  int          fstart_q[$];
  bit          fok_q[$];
  logic [17:0] addr_q[$];
  logic [17:0] prev_sa = '0;
  int          done_n = 0, done_cyc = 0, busy_rise = 0, pos = 0;
  bit          busy_seen = 0, tx_low_seen = 0, we_low_seen = 0, prev_busy = 0, inframe = 0;
  logic [9:0]  sh;

  always @(negedge Clock) begin
    if (Resetn !== 1'b1) begin
      inframe = 0;
    end else begin
      if (UART_TX_O === 1'b0) tx_low_seen = 1;
      if (SRAM_we_n !== 1'b1) we_low_seen = 1;
      if (Busy === 1'b1 && !prev_busy) begin busy_rise = cyc; busy_seen = 1; end
      if (Done === 1'b1) begin done_n++; done_cyc = cyc; end
      if (SRAM_address !== prev_sa) begin
        addr_q.push_back(SRAM_address);
        prev_sa = SRAM_address;
      end
      if (!inframe) begin
        if (UART_TX_O === 1'b0) begin
          inframe = 1; pos = 0;
          fstart_q.push_back(cyc);
        end
      end else begin
        pos++;
      end
      if (inframe && (pos % CPB) == CPB / 2) begin
        sh[pos / CPB] = UART_TX_O;
        if (pos / CPB == 9) begin
          bytes_q.push_back(sh[8:1]);
          fok_q.push_back(sh[0] == 1'b0 && sh[9] == 1'b1);
          inframe = 0;
        end
      end
    end
    prev_busy = (Busy === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [17:0] b, input logic [17:0] c);
    @(posedge Clock); #1;
    Start = 1'b1; Base_address = b; Word_count = c;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  // Reference: word i of the job is mem[base+i mod 2^18], high byte first;
  // each word occupies WORD_T cycles from Busy rising.
  task automatic run_job(input logic [17:0] b, input logic [17:0] c,
                         input int interfere, input string tag);
    logic [7:0]  eb[$];
    logic [17:0] ea[$];
    logic [17:0] a;
    int          k, n, gap;
    for (int i = 0; i < int'(c); i++) begin
      a = b + 18'(i);
      eb.push_back(mem[a][15:8]);
      eb.push_back(mem[a][7:0]);
      ea.push_back(a);
    end
    if (ea[0] === SRAM_address) void'(ea.pop_front());
    bytes_q.delete(); fstart_q.delete(); fok_q.delete(); addr_q.delete();
    done_n = 0; busy_seen = 0;
    start_job(b, c);
    if (interfere > 0) begin
      repeat (interfere) @(posedge Clock);
      #1; Start = 1'b1; Base_address = b ^ 18'h155; Word_count = c + 18'd5;
      @(posedge Clock); #1; Start = 1'b0;
    end
    k = 0;
    while (done_n == 0 && k < int'(c) * WORD_T + 100) begin
      @(posedge Clock); k++;
    end
    chk({tag, "_done_seen"}, done_n, 1);
    repeat (5) @(posedge Clock);
    #1;
    chk({tag, "_done_once"}, done_n, 1);
    chk({tag, "_busy_low"}, Busy, 0);
    chk({tag, "_done_time"}, done_cyc - busy_rise, int'(c) * WORD_T);
    chk({tag, "_nbytes"}, bytes_q.size(), eb.size());
    n = (bytes_q.size() < eb.size()) ? bytes_q.size() : eb.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), bytes_q[i], eb[i]);
      chk($sformatf("%s_frame%0d", tag, i), fok_q[i], 1);
      if (i == 0) gap = fstart_q[0] - busy_rise;
      else        gap = fstart_q[i] - fstart_q[i-1];
      chk($sformatf("%s_fstart%0d", tag, i), gap,
          (i == 0) ? LAT + 2 : ((i % 2) ? 10 * CPB : WORD_T - 10 * CPB));
    end
    chk({tag, "_naddr"}, addr_q.size(), ea.size());
    n = (addr_q.size() < ea.size()) ? addr_q.size() : ea.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_q[i], ea[i]);
  endtask

  logic [17:0] rb, rc;

  initial begin
    Resetn = 1'b0; Start = 1'b0; Base_address = '0; Word_count = '0;
    mem[18'h00100] = 16'hA55A;
    mem[18'h3FFFE] = 16'h0102;
    mem[18'h3FFFF] = 16'h0304;
    mem[18'h00000] = 16'h0506;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_tx", UART_TX_O, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_addr", SRAM_address, 0);
    Resetn = 1'b1;

    run_job(18'h00100, 18'd1, 0, "single");
    run_job(18'h3FFFE, 18'd3, 0, "wrap");

    // Zero count: immediate Done, nothing else moves.
    busy_seen = 0; tx_low_seen = 0; done_n = 0;
    start_job(18'h00055, 18'd0);
    chk("zero_done_pulse", Done, 1);
    chk("zero_busy", Busy, 0);
    @(posedge Clock); #1;
    chk("zero_done_drop", Done, 0);
    repeat (40) @(posedge Clock);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_tx_low", tx_low_seen, 0);
    chk("zero_done_n", done_n, 1);

    run_job(18'h00100, 18'd1, 30, "ignore_start");

    // Reset during data bit 1 of 0xA5 (a 0 on the line).
    done_n = 0;
    start_job(18'h00100, 18'd1);
    repeat (LAT + 2 + 9) @(posedge Clock);
    #1;
    chk("midrst_pre_tx", UART_TX_O, 0);
    Resetn = 1'b0;
    #1;
    chk("midrst_tx", UART_TX_O, 1);
    chk("midrst_busy", Busy, 0);
    repeat (5) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    repeat (120) @(posedge Clock);
    chk("midrst_no_done", done_n, 0);
    run_job(18'h00100, 18'd1, 0, "post_rst");

    for (int t = 0; t < 6; t++) begin
      rb = ($urandom_range(0, 1) == 1) ? 18'h3FFFF - 18'($urandom_range(0, 3)) : 18'($urandom);
      rc = 18'($urandom_range(1, 4));
      for (int i = 0; i < int'(rc); i++) mem[rb + 18'(i)] = 16'($urandom);
      run_job(rb, rc, 0, $sformatf("rnd%0d", t));
    end

    chk("never_wrote", we_low_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
